vga_write_bridge: RTL and testbench



---
 rtl/vga_pkg.sv | 19 +
 rtl/vga_req_fifo.sv | 59 +++++
 rtl/vga_write_bridge.sv | 133 +++++++++++++
 tb/tb_vga_write_bridge.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA write bridge and its request FIFO.
package vga_pkg;

    localparam int          PIX_AW_DEF     = 14;
    localparam logic [31:0] CTRL_ADDR_DEF  = 32'h0000_8000;
    localparam int          FILL_START_BIT = 31;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_req_t;

endpackage

// File: rtl/vga_req_fifo.sv
// Small synchronous FIFO of CPU write requests; power-of-two depth, wrapping pointers.
module vga_req_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  wr_req_t i_data,
    input  logic    i_pop,
    output wr_req_t o_data,
    output logic    o_full,
    output logic    o_empty
);

    localparam int AW = $clog2(DEPTH);

    wr_req_t        r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_count;
    logic           w_do_push;
    logic           w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vga_write_bridge.sv
// CPU-to-VGA write bridge: buffers stores, replays them as one-cycle writes,
// and runs a hardware clear-screen fill triggered by a control-register write.
module vga_write_bridge
    import vga_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter int          PIX_AW     = PIX_AW_DEF,
    parameter logic [31:0] CTRL_ADDR  = CTRL_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [3:0]  vga_we,
    output logic [31:0] vga_addr,
    output logic [31:0] vga_data,
    output logic        busy,
    output logic        fill_done
);

    localparam logic [PIX_AW-1:0] LAST_IDX = '1;

    wr_req_t            w_in;
    wr_req_t            w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PIX_AW-1:0]  r_idx;
    logic [PIX_AW-1:0]  w_idx_nxt;
    logic [11:0]        r_colour;
    logic [11:0]        w_colour_nxt;
    logic [3:0]         r_vga_we;
    logic [3:0]         w_we_nxt;
    logic [31:0]        r_vga_addr;
    logic [31:0]        w_addr_nxt;
    logic [31:0]        r_vga_data;
    logic [31:0]        w_data_nxt;
    logic               r_done;
    logic               w_done_nxt;

    assign w_in      = '{we: req_we, addr: req_addr, data: req_wdata};
    assign req_ready = !w_full;
    assign w_push    = req_valid && !w_full;
    assign busy      = (r_state == FILL) || !w_empty;
    assign vga_we    = r_vga_we;
    assign vga_addr  = r_vga_addr;
    assign vga_data  = r_vga_data;
    assign fill_done = r_done;

    vga_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_colour_nxt = r_colour;
        w_we_nxt     = 4'b0000;
        w_addr_nxt   = 32'h0;
        w_data_nxt   = 32'h0;
        w_done_nxt   = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    // Zero-enable entries are dropped before any address decode.
                    if (w_head.we != 4'b0000) begin
                        if (w_head.addr == CTRL_ADDR) begin
                            w_colour_nxt = w_head.data[11:0];
                            if (w_head.data[FILL_START_BIT]) begin
                                w_state_nxt = FILL;
                                w_idx_nxt   = '0;
                            end
                        end else begin
                            w_we_nxt   = w_head.we;
                            w_addr_nxt = w_head.addr;
                            w_data_nxt = w_head.data;
                        end
                    end
                end
            end
            FILL: begin
                w_we_nxt   = 4'b0011;
                w_addr_nxt = 32'({r_idx, 1'b0});
                w_data_nxt = {20'h0, r_colour};
                w_idx_nxt  = r_idx + PIX_AW'(1);
                if (r_idx == LAST_IDX) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_colour   <= 12'h000;
            r_vga_we   <= 4'b0000;
            r_vga_addr <= 32'h0;
            r_vga_data <= 32'h0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_colour   <= w_colour_nxt;
            r_vga_we   <= w_we_nxt;
            r_vga_addr <= w_addr_nxt;
            r_vga_data <= w_data_nxt;
            r_done     <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_vga_write_bridge.sv
// Scoreboard bench for vga_write_bridge: directed stores, fills and a mid-fill reset.
module tb_vga_write_bridge;
    import vga_pkg::*;

    localparam logic [31:0] CTRL = 32'h0000_8000;
    localparam int          NPIX = 16384;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_we = 4'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  vga_we;
    logic [31:0] vga_addr;
    logic [31:0] vga_data;
    logic        busy;
    logic        fill_done;

    vga_write_bridge #(
        .FIFO_DEPTH (4),
        .PIX_AW     (14),
        .CTRL_ADDR  (CTRL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .vga_we    (vga_we),
        .vga_addr  (vga_addr),
        .vga_data  (vga_data),
        .busy      (busy),
        .fill_done (fill_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        done;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write or fill_done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && (vga_we != 4'b0000 || fill_done)) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got we=%h addr=%h data=%h done=%b cyc=%0d, expected no write",
                         vga_we, vga_addr, vga_data, fill_done, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (vga_we !== mon_e.we || vga_addr !== mon_e.addr || vga_data !== mon_e.data ||
                    fill_done !== mon_e.done || (mon_e.at >= 0 && cyc != mon_e.at)) begin
                    fails++;
                    $display("FAIL vga_write: got we=%h addr=%h data=%h done=%b cyc=%0d, expected we=%h addr=%h data=%h done=%b cyc=%0d",
                             vga_we, vga_addr, vga_data, fill_done, cyc,
                             mon_e.we, mon_e.addr, mon_e.data, mon_e.done, mon_e.at);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [3:0] we, input logic [31:0] a, input logic [31:0] d,
                        output int edge_n);
        int g;
        g = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready) begin
            @(negedge clk);
            g++;
            if (g > 40000) begin
                $display("FAIL send_timeout: got req_ready=0 for %0d cycles, expected acceptance", g);
                $fatal(1, "send timeout");
            end
        end
        edge_n = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int g;
        g = 0;
        while ((busy || sb.size() != 0) && g < 40000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40000) begin
            tests++;
            fails++;
            $display("FAIL %s_drain: got busy=%b pending=%0d, expected idle", name, busy, sb.size());
        end
        @(negedge clk);
    endtask

    task automatic push_fill(input int first_at, input logic [11:0] colour);
        for (int i = 0; i < NPIX; i++) begin
            sb.push_back('{4'b0011, 32'(i * 2), {20'h0, colour}, (i == NPIX - 1), first_at + i});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [3:0]  s2_we   [6] = '{4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1100};
    logic [31:0] s2_addr [6] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h1FFE};
    logic [31:0] s2_data [6] = '{32'hA5A5_0001, 32'h0000_0011, 32'h0000_2200, 32'h0033_0000,
                                 32'h4400_0000, 32'hFFFF_0000};

    initial begin
        int n;
        int n0;
        int c;
        int p;
        int last;
        int e [6];
        int r [5];

        repeat (3) @(negedge clk);
        check("rst_vga_we",    32'(vga_we),    32'h0);
        check("rst_vga_addr",  vga_addr,       32'h0);
        check("rst_vga_data",  vga_data,       32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_fill_done", 32'(fill_done), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        rst = 1'b1;
        @(negedge clk);

        // Single write: visible exactly one cycle, one edge after acceptance.
        send(4'b0011, 32'h0000_0010, 32'h0000_0ABC, n);
        sb.push_back('{4'b0011, 32'h10, 32'hABC, 1'b0, n + 1});
        @(negedge clk);
        check("s1_busy_drop", 32'(busy), 32'h0);
        wait_drain("s1");

        // Six back-to-back stores drain at one per cycle without stalling.
        for (int i = 0; i < 6; i++) begin
            send(s2_we[i], s2_addr[i], s2_data[i], e[i]);
            sb.push_back('{s2_we[i], s2_addr[i], s2_data[i], 1'b0, e[i] + 1});
        end
        for (int i = 1; i < 6; i++) begin
            check("s2_no_stall", 32'(e[i]), 32'(e[0] + i));
        end
        wait_drain("s2");

        // Full fill, with five stores queued behind it.
        send(4'hF, CTRL, 32'h8000_0F00, c);
        p    = c + 1;
        last = p + NPIX;
        push_fill(p + 1, 12'hF00);
        for (int k = 0; k < 4; k++) begin
            send(4'b1100, 32'h0000_0200 + 32'(k * 4), 32'hC0DE_0000 + 32'(k), r[k]);
            sb.push_back('{4'b1100, 32'h0000_0200 + 32'(k * 4), 32'hC0DE_0000 + 32'(k), 1'b0, last + 1 + k});
        end
        check("s4_accept4",   32'(r[3]),      32'(c + 4));
        check("s4_ready_low", 32'(req_ready), 32'h0);
        check("s4_busy",      32'(busy),      32'h1);
        sb.push_back('{4'b1111, 32'h0000_0210, 32'hC0DE_0004, 1'b0, last + 5});
        send(4'b1111, 32'h0000_0210, 32'hC0DE_0004, r[4]);
        check("s4_fifth_accept", 32'(r[4]), 32'(last + 2));
        wait_drain("s4");

        // Control write without the start bit: colour only, no writes.
        send(4'hF, CTRL, 32'h0000_0123, n);
        wait_drain("ctrl_nostart");
        check("ctrl_nostart_idle", 32'(busy), 32'h0);

        // Reset in the middle of a fill aborts everything at once.
        send(4'hF, CTRL, 32'h8000_0555, c);
        push_fill(c + 2, 12'h555);
        repeat (1000) @(negedge clk);
        check("s5_in_fill", 32'(busy), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("s5_abort_we",    32'(vga_we),    32'h0);
        check("s5_abort_addr",  vga_addr,       32'h0);
        check("s5_abort_busy",  32'(busy),      32'h0);
        check("s5_abort_ready", 32'(req_ready), 32'h1);
        check("s5_abort_done",  32'(fill_done), 32'h0);
        sb.delete();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("s5_post_busy", 32'(busy), 32'h0);
        send(4'b0011, 32'h0000_0010, 32'h0000_0ABC, n);
        sb.push_back('{4'b0011, 32'h10, 32'hABC, 1'b0, n + 1});
        wait_drain("s5_post");

        // Zero-enable request is swallowed; the next store still lands one cycle after its pop.
        send(4'b0000, 32'h0000_0020, 32'hDEAD_BEEF, n0);
        send(4'b0001, 32'h0000_0024, 32'h0000_0055, n);
        sb.push_back('{4'b0001, 32'h24, 32'h55, 1'b0, n + 1});
        wait_drain("s6");

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
